// File: rtl/rtlreqarb.sv
// rtlreqarb: round-robin scheduler that shares one downstream valid/ready
// consumer between NREQ FIFO-backed req/ack/vld request sources.
// One queue is granted at a time: a one-cycle ack pops an entry, the entry is
// captured when vld of the granted source returns, and it is held on the
// output register, tagged with the source id, until the consumer accepts it.
// Optional feature macro: RTLREQARB_TIMEOUT_EN adds a vld watchdog, the TOUT
// parameter and the errtout output pulse.
module rtlreqarb #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 128
`ifdef RTLREQARB_TIMEOUT_EN
    ,
    parameter int TOUT  = 15
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   reqinfo,
    output logic [NREQ-1:0]         ack,
    input  logic [NREQ-1:0]         vld,
    input  logic [NREQ-1:0]         reqmsk,
    output logic                    outvld,
    input  logic                    outrdy,
    output logic [WIDTH-1:0]        outinfo,
    output logic [IDW-1:0]          outid,
    output logic                    busy,
    output logic [15:0]             grantcnt
`ifdef RTLREQARB_TIMEOUT_EN
    ,
    output logic                    errtout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

`ifdef RTLREQARB_TIMEOUT_EN
    // Watchdog width: enough to hold TOUT, never narrower than 4 bits.
    localparam int CNTW = ($clog2(TOUT + 1) < 4) ? 4 : $clog2(TOUT + 1);
`endif

    // First set bit of e searching upward from (last+1) mod NREQ, wrapping.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] e,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] win;
        logic           found;
        int             idx;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && e[idx]) begin
                win   = IDW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    state_t            state_q, state_d;
    logic [IDW-1:0]    g_q, g_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              outvld_q, outvld_d;
    logic [WIDTH-1:0]  outinfo_q, outinfo_d;
    logic [IDW-1:0]    outid_q, outid_d;
    logic              busy_q, busy_d;
    logic [15:0]       grantcnt_q, grantcnt_d;
`ifdef RTLREQARB_TIMEOUT_EN
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              errtout_q, errtout_d;
`endif

    logic [NREQ-1:0]   elig_s;
    logic              any_elig_s;
    logic [IDW-1:0]    pick_s;
    logic              vld_g_s;
    logic [WIDTH-1:0]  info_g_s;

    // Eligibility, round-robin winner and the granted source's strobe/data.
    always_comb begin
        elig_s     = req & ~reqmsk;
        any_elig_s = |elig_s;
        pick_s     = rr_pick(elig_s, last_q);
        vld_g_s    = vld[g_q];
        info_g_s   = reqinfo[int'(g_q) * WIDTH +: WIDTH];
    end

    // Next-state logic: arbitration, grant pulse, capture and output handshake.
    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        last_d     = last_q;
        ack_d      = '0;
        outvld_d   = outvld_q;
        outinfo_d  = outinfo_q;
        outid_d    = outid_q;
        grantcnt_d = grantcnt_q;
`ifdef RTLREQARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        errtout_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_elig_s) begin
                    state_d = S_GRANT;
                    g_d     = pick_s;
                    last_d  = pick_s;
                    ack_d   = idx_onehot(pick_s);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // The ack pulse is already on the output register this cycle.
                state_d = S_WAIT;
`ifdef RTLREQARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // Only the granted source's strobe counts; others are ignored.
                if (vld_g_s) begin
                    state_d    = S_OUT;
                    outinfo_d  = info_g_s;
                    outid_d    = g_q;
                    outvld_d   = 1'b1;
                    grantcnt_d = grantcnt_q + 16'd1;
                end
`ifdef RTLREQARB_TIMEOUT_EN
                else if (cnt_q == CNTW'(TOUT - 1)) begin
                    // Counter reaches TOUT this cycle with no data: abandon.
                    state_d   = S_IDLE;
                    errtout_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + CNTW'(1);
                end
`else
                else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_OUT: begin
                if (outrdy) begin
                    outvld_d = 1'b0;
                    // Back-to-back: arbitrate in the acceptance cycle itself.
                    if (any_elig_s) begin
                        state_d = S_GRANT;
                        g_d     = pick_s;
                        last_d  = pick_s;
                        ack_d   = idx_onehot(pick_s);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d  = S_IDLE;
                outvld_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; async reset discards any pending entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            g_q        <= '0;
            last_q     <= IDW'(NREQ - 1);
            ack_q      <= '0;
            outvld_q   <= 1'b0;
            outinfo_q  <= '0;
            outid_q    <= '0;
            busy_q     <= 1'b0;
            grantcnt_q <= 16'd0;
`ifdef RTLREQARB_TIMEOUT_EN
            cnt_q      <= '0;
            errtout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            last_q     <= last_d;
            ack_q      <= ack_d;
            outvld_q   <= outvld_d;
            outinfo_q  <= outinfo_d;
            outid_q    <= outid_d;
            busy_q     <= busy_d;
            grantcnt_q <= grantcnt_d;
`ifdef RTLREQARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            errtout_q  <= errtout_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign outvld   = outvld_q;
    assign outinfo  = outinfo_q;
    assign outid    = outid_q;
    assign busy     = busy_q;
    assign grantcnt = grantcnt_q;
`ifdef RTLREQARB_TIMEOUT_EN
    assign errtout  = errtout_q;
`endif

endmodule
